// File: rtl/debounced_pio.sv
// Avalon-MM PIO with synchronised, optionally debounced inputs, edge capture and a level IRQ.
// Define DEBOUNCED_PIO_DEBOUNCE_EN to build in the prescaler and 3-sample debounce history.

module debounced_pio_lane (
    input  logic clk_clk,
    input  logic reset_reset_n,
    input  logic tick_i,
    input  logic sync_i,
    output logic deb_o
);
    logic [2:0] hist_q;
    logic       deb_q;

    // The debounced bit only moves once three consecutive tick samples agree.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            hist_q <= '0;
            deb_q  <= 1'b0;
        end else begin
            if (tick_i)
                hist_q <= {hist_q[1:0], sync_i};
            if (&hist_q)
                deb_q <= 1'b1;
            else if (~|hist_q)
                deb_q <= 1'b0;
        end
    end

    assign deb_o = deb_q;
endmodule

module debounced_pio #(
    parameter int WIDTH    = 8,
    parameter int TICK_DIV = 50000
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [1:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    input  logic [WIDTH-1:0] pio_in_export,
    output logic [WIDTH-1:0] pio_out_export,
    output logic             irq
);
    localparam logic [1:0] A_DATA = 2'd0;
    localparam logic [1:0] A_INFO = 2'd1;
    localparam logic [1:0] A_MASK = 2'd2;
    localparam logic [1:0] A_EDGE = 2'd3;

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_prev_q;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             irq_q, irq_d;
    logic [WIDTH-1:0] wr_data;
    logic             unused_bits;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= pio_in_export;
            sync2_q <= sync1_q;
        end
    end

`ifdef DEBOUNCED_PIO_DEBOUNCE_EN
    localparam bit DEB_EN = 1'b1;
    localparam int CW     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] presc_q;
    logic          tick;

    assign tick = (presc_q == CW'(TICK_DIV - 1));

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n)
            presc_q <= '0;
        else
            presc_q <= tick ? '0 : presc_q + CW'(1);
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        debounced_pio_lane u_lane (
            .clk_clk       (clk_clk),
            .reset_reset_n (reset_reset_n),
            .tick_i        (tick),
            .sync_i        (sync2_q[g]),
            .deb_o         (deb[g])
        );
    end

    assign unused_bits = ^avs_writedata;
`else
    localparam bit DEB_EN = 1'b0;

    assign deb         = sync2_q;
    assign unused_bits = ^{avs_writedata, 32'(TICK_DIV)};
`endif

    assign wr_data = avs_writedata[WIDTH-1:0];

    always_comb begin
        out_d   = out_q;
        mask_d  = mask_q;
        edge_d  = edge_q;
        rdata_d = rdata_q;

        if (avs_write) begin
            case (avs_address)
                A_DATA:  out_d  = wr_data;
                A_MASK:  mask_d = wr_data;
                A_EDGE:  edge_d = edge_q & ~wr_data;
                default: ;
            endcase
        end
        // New edges are ORed in after the clear so a coincident set wins.
        edge_d = edge_d | (deb ^ deb_prev_q);

        // Read mux samples current state, so a same-cycle write is not visible yet.
        if (avs_read) begin
            rdata_d = '0;
            case (avs_address)
                A_DATA: rdata_d[WIDTH-1:0] = deb;
                A_INFO: begin
                    rdata_d[5:0] = 6'(WIDTH);
                    rdata_d[8]   = DEB_EN;
                end
                A_MASK: rdata_d[WIDTH-1:0] = mask_q;
                A_EDGE: rdata_d[WIDTH-1:0] = edge_q;
                default: ;
            endcase
        end

        irq_d = |(edge_q & mask_q);
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            deb_prev_q <= '0;
            out_q      <= '0;
            mask_q     <= '0;
            edge_q     <= '0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            deb_prev_q <= deb;
            out_q      <= out_d;
            mask_q     <= mask_d;
            edge_q     <= edge_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
        end
    end

    assign avs_readdata   = rdata_q;
    assign pio_out_export = out_q;
    assign irq            = irq_q;
endmodule

// File: tb/tb_debounced_pio.sv
// Scoreboard bench for debounced_pio (WIDTH=8, TICK_DIV=4); follows DEBOUNCED_PIO_DEBOUNCE_EN.

module tb_debounced_pio;
    localparam int W  = 8;
    localparam int TD = 4;
`ifdef DEBOUNCED_PIO_DEBOUNCE_EN
    localparam logic [31:0] INFO = 32'h108;
    localparam int          LAT  = 16;
`else
    localparam logic [31:0] INFO = 32'h008;
    localparam int          LAT  = 3;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   avs_address = '0;
    logic         avs_read = 1'b0;
    logic         avs_write = 1'b0;
    logic [31:0]  avs_writedata = '0;
    logic [31:0]  avs_readdata;
    logic [W-1:0] pio_in = '0;
    logic [W-1:0] pio_out;
    logic         irq;

    debounced_pio #(.WIDTH(W), .TICK_DIV(TD)) dut (
        .clk_clk        (clk),
        .reset_reset_n  (rst_n),
        .avs_address    (avs_address),
        .avs_read       (avs_read),
        .avs_write      (avs_write),
        .avs_writedata  (avs_writedata),
        .avs_readdata   (avs_readdata),
        .pio_in_export  (pio_in),
        .pio_out_export (pio_out),
        .irq            (irq)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } rd_t;
    rd_t sb[$];

    logic rd_seen = 1'b0;
    logic poll = 1'b0;

    always @(posedge clk) rd_seen <= avs_read && !poll;

    always @(negedge clk) begin
        if (rd_seen) begin
            rd_t e;
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk(e.tag, avs_readdata, e.exp);
            end
        end
    end

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        avs_address = a;
        avs_read    = 1'b1;
        sb.push_back('{tag: tag, exp: exp});
        @(negedge clk);
        avs_read = 1'b0;
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    // Reads every cycle (optionally with a same-cycle write) until bit b shows v.
    task automatic poll_bit(input logic [1:0] a, input int b, input logic v, input int maxc,
                            input logic wen, input logic [31:0] wd,
                            output int cyc, output logic seen);
        avs_address   = a;
        avs_read      = 1'b1;
        avs_write     = wen;
        avs_writedata = wd;
        poll          = 1'b1;
        cyc  = 0;
        seen = 1'b0;
        while (cyc < maxc && !seen) begin
            @(negedge clk);
            cyc++;
            seen = (avs_readdata[b] === v);
        end
        avs_read  = 1'b0;
        avs_write = 1'b0;
        poll      = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int   cyc;
        logic seen;

        repeat (3) @(negedge clk);
        chk("rst_rdata", avs_readdata, 32'h0);
        chk("rst_pio_out", {24'h0, pio_out}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        rd(2'd0, 32'h00, "data_rst");
        rd(2'd1, INFO,   "info");
        rd(2'd2, 32'h00, "mask_rst");
        rd(2'd3, 32'h00, "edge_rst");
        chk("irq_rst", {31'h0, irq}, 32'h0);

        pio_in = 8'h01;
        poll_bit(2'd0, 0, 1'b1, 40, 1'b0, 32'h0, cyc, seen);
        chk("data0_seen", {31'h0, seen}, 32'h1);
        chk("data0_lat", {31'h0, cyc <= LAT}, 32'h1);
        repeat (3) @(negedge clk);
        rd(2'd3, 32'h01, "edge0");
        rd(2'd0, 32'h01, "data0");
        chk("irq_masked", {31'h0, irq}, 32'h0);

        wr(2'd2, 32'h01);
        chk("irq_lag", {31'h0, irq}, 32'h0);
        @(negedge clk);
        chk("irq_set", {31'h0, irq}, 32'h1);
        wr(2'd3, 32'h01);
        chk("irq_hold", {31'h0, irq}, 32'h1);
        @(negedge clk);
        chk("irq_clr", {31'h0, irq}, 32'h0);
        rd(2'd3, 32'h00, "edge_w1c");

`ifdef DEBOUNCED_PIO_DEBOUNCE_EN
        pio_in = 8'h09;
        repeat (7) @(negedge clk);
        pio_in = 8'h01;
        repeat (25) @(negedge clk);
        rd(2'd0, 32'h01, "glitch_data");
        rd(2'd3, 32'h00, "glitch_edge");
        chk("glitch_irq", {31'h0, irq}, 32'h0);
`endif

        wr(2'd2, 32'hFFFF_FFFF);
        rd(2'd2, 32'hFF, "mask_wide");
        wr(2'd1, 32'h0);
        rd(2'd1, INFO, "info_ro");

        // Clear bit 2 every cycle while its edge arrives: the set must still be seen once.
        pio_in = 8'h05;
        poll_bit(2'd3, 2, 1'b1, 40, 1'b1, 32'h4, cyc, seen);
        chk("setwin_seen", {31'h0, seen}, 32'h1);
        rd(2'd3, 32'h00, "setwin_after");
        rd(2'd0, 32'h05, "data2");

        pio_in = 8'h25;
        poll_bit(2'd0, 5, 1'b1, 40, 1'b0, 32'h0, cyc, seen);
        chk("bit5_rise_seen", {31'h0, seen}, 32'h1);
        chk("bit5_rise_lat", {31'h0, cyc <= LAT}, 32'h1);
        pio_in = 8'h05;
        poll_bit(2'd0, 5, 1'b0, 40, 1'b0, 32'h0, cyc, seen);
        chk("bit5_fall_seen", {31'h0, seen}, 32'h1);
        chk("bit5_fall_lat", {31'h0, cyc <= LAT}, 32'h1);
        repeat (2) @(negedge clk);
        rd(2'd3, 32'h20, "edge5");

        wr(2'd0, 32'hA5);
        chk("pio_out_a5", {24'h0, pio_out}, 32'hA5);
        wr(2'd0, 32'hFFFF_FF3C);
        chk("pio_out_3c", {24'h0, pio_out}, 32'h3C);

        // Reset mid-debounce with bit 6 partial and bit 7 held through reset.
        pio_in = 8'h40;
        repeat (8) @(negedge clk);
        rst_n  = 1'b0;
        pio_in = 8'h80;
        @(negedge clk);
        chk("rst2_pio_out", {24'h0, pio_out}, 32'h0);
        chk("rst2_irq", {31'h0, irq}, 32'h0);
        chk("rst2_rdata", avs_readdata, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        rd(2'd3, 32'h80, "edge_held_rst");
        rd(2'd0, 32'h80, "data_held_rst");
        rd(2'd2, 32'h00, "mask_after_rst");
        chk("irq_after_rst", {31'h0, irq}, 32'h0);

        repeat (2) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
